oled_i2c_tx: RTL

- Hardware I2C write engine for the SSD1306 OLED. It sits directly downstream of the CPU's 16-bit P output port and replaces GPIO bit-banging of SCL/SDA.
- The CPU posts one byte per request by writing P and toggling P[15].
- The engine performs a complete I2C transaction: START, address, control byte, data byte, STOP.
- It returns a status word that the CPU reads back through its rx input using the IN instruction.

---
 rtl/oled_i2c_tx_if.sv | 31 +++
 rtl/oled_i2c_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/oled_i2c_tx_if.sv
// CPU-port and I2C pad bundle for the SSD1306 write engine.
// master: the engine itself; slave: the CPU/pad environment around it.
interface oled_i2c_tx_if;
    logic [15:0] p_word;
    logic [15:0] status;
    logic        scl;
    logic        sda_o;
    logic        sda_oe;
    logic        sda_i;
    logic        oled_res;

    modport master (
        input  p_word,
        input  sda_i,
        output status,
        output scl,
        output sda_o,
        output sda_oe,
        output oled_res
    );

    modport slave (
        output p_word,
        output sda_i,
        input  status,
        input  scl,
        input  sda_o,
        input  sda_oe,
        input  oled_res
    );
endinterface

// File: rtl/oled_i2c_tx.sv
// Hardware I2C write engine for the SSD1306 OLED: one START / address /
// control / data / STOP transaction per toggle of p_word[15].
module oled_i2c_tx #(
    parameter int unsigned CLK_DIV  = 25,
    parameter logic [6:0]  DEV_ADDR = 7'h3C
) (
    input  logic          clk_pll,
    input  logic          rst,
    oled_i2c_tx_if.master bus
);

    localparam int unsigned   QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BYTE,
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    // step: phase index inside START/STOP, quarter index inside a bit
    logic [1:0]    step, step_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          ack_bit, ack_bit_n;
    logic [1:0]    byte_idx, byte_idx_n;
    logic [7:0]    data, data_n;
    logic          dc, dc_n;
    logic          req_seen, req_seen_n;
    logic          busy, busy_n;
    logic          nack, nack_n;
    logic          done_tgl, done_tgl_n;
    logic          scl_q, scl_n;
    logic          oe_q, oe_n;
    logic [1:0]    sda_sync;
    logic          oled_res_q;
    logic          tick;
    logic          unused_bits;

    assign tick        = (qcnt == Q_LAST);
    assign unused_bits = ^bus.p_word[14:10];

    // Bus levels for a given phase; registered so the pads never glitch.
    function automatic logic [1:0] bus_drive(
        input state_t     st,
        input logic [1:0] stp,
        input logic [2:0] bc,
        input logic       ak,
        input logic [1:0] bi,
        input logic [7:0] d,
        input logic       c
    );
        logic [7:0] b;
        logic       scl_v;
        logic       oe_v;
        case (bi)
            2'd0:    b = {DEV_ADDR, 1'b0};
            2'd1:    b = c ? 8'h40 : 8'h00;
            default: b = d;
        endcase
        scl_v = 1'b1;
        oe_v  = 1'b0;
        case (st)
            S_START: begin
                scl_v = (stp == 2'd0);
                oe_v  = 1'b1;
            end
            S_BYTE: begin
                scl_v = stp[1];
                oe_v  = ~ak & ~b[bc];
            end
            S_STOP: begin
                scl_v = (stp != 2'd0);
                oe_v  = (stp != 2'd2);
            end
            default: ;
        endcase
        return {scl_v, oe_v};
    endfunction

    // Next-state, counter and bus-level computation.
    always_comb begin
        state_n    = state;
        qcnt_n     = qcnt;
        step_n     = step;
        bit_cnt_n  = bit_cnt;
        ack_bit_n  = ack_bit;
        byte_idx_n = byte_idx;
        data_n     = data;
        dc_n       = dc;
        req_seen_n = req_seen;
        busy_n     = busy;
        nack_n     = nack;
        done_tgl_n = done_tgl;

        if (state == S_IDLE) begin
            qcnt_n = '0;
        end else begin
            qcnt_n = tick ? '0 : qcnt + QW'(1);
        end

        case (state)
            S_IDLE: begin
                if (bus.p_word[15] != req_seen) begin
                    req_seen_n = bus.p_word[15];
                    data_n     = bus.p_word[7:0];
                    dc_n       = bus.p_word[8];
                    busy_n     = 1'b1;
                    nack_n     = 1'b0;
                    step_n     = '0;
                    state_n    = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (step == 2'd0) begin
                        step_n = 2'd1;
                    end else begin
                        step_n     = '0;
                        bit_cnt_n  = 3'd7;
                        ack_bit_n  = 1'b0;
                        byte_idx_n = '0;
                        state_n    = S_BYTE;
                    end
                end
            end
            S_BYTE: begin
                if (tick) begin
                    if (step != 2'd3) begin
                        step_n = step + 2'd1;
                    end else begin
                        step_n = '0;
                        if (!ack_bit) begin
                            if (bit_cnt == 3'd0) begin
                                ack_bit_n = 1'b1;
                            end else begin
                                bit_cnt_n = bit_cnt - 3'd1;
                            end
                        end else begin
                            // End of ACK q3: sync output is the slave's answer.
                            ack_bit_n = 1'b0;
                            bit_cnt_n = 3'd7;
                            if (sda_sync[1]) begin
                                nack_n  = 1'b1;
                                state_n = S_STOP;
                            end else if (byte_idx == 2'd2) begin
                                state_n = S_STOP;
                            end else begin
                                byte_idx_n = byte_idx + 2'd1;
                            end
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (step != 2'd2) begin
                        step_n = step + 2'd1;
                    end else begin
                        step_n     = '0;
                        busy_n     = 1'b0;
                        done_tgl_n = ~done_tgl;
                        state_n    = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        {scl_n, oe_n} = bus_drive(state_n, step_n, bit_cnt_n, ack_bit_n,
                                  byte_idx_n, data_n, dc_n);
    end

    // State, counters, status and pad registers.
    always_ff @(posedge clk_pll or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            qcnt       <= '0;
            step       <= '0;
            bit_cnt    <= 3'd7;
            ack_bit    <= 1'b0;
            byte_idx   <= '0;
            data       <= '0;
            dc         <= 1'b0;
            req_seen   <= 1'b0;
            busy       <= 1'b0;
            nack       <= 1'b0;
            done_tgl   <= 1'b0;
            scl_q      <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state      <= state_n;
            qcnt       <= qcnt_n;
            step       <= step_n;
            bit_cnt    <= bit_cnt_n;
            ack_bit    <= ack_bit_n;
            byte_idx   <= byte_idx_n;
            data       <= data_n;
            dc         <= dc_n;
            req_seen   <= req_seen_n;
            busy       <= busy_n;
            nack       <= nack_n;
            done_tgl   <= done_tgl_n;
            scl_q      <= scl_n;
            oe_q       <= oe_n;
        end
    end

    // Two-flop synchroniser for the SDA pad; idles at the pulled-up level.
    always_ff @(posedge clk_pll or negedge rst) begin
        if (!rst) begin
            sda_sync <= '1;
        end else begin
            sda_sync <= {sda_sync[0], bus.sda_i};
        end
    end

    // OLED reset level follows the CPU port every cycle.
    always_ff @(posedge clk_pll or negedge rst) begin
        if (!rst) begin
            oled_res_q <= 1'b0;
        end else begin
            oled_res_q <= bus.p_word[9];
        end
    end

    assign bus.scl      = scl_q;
    assign bus.sda_oe   = oe_q;
    assign bus.sda_o    = 1'b0;
    assign bus.oled_res = oled_res_q;
    assign bus.status   = {13'd0, done_tgl, nack, busy};

endmodule
